alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Registered issue/retire controller that sits directly upstream of the combinational ALU and also captures its outputs. It accepts operations over a valid/ready handshake, drives the ALU operand/opcode/cin inputs from registers, and captures the result and flags one cycle later. It presents them downstream over a valid/ready handshake. It keeps an accumulator (operand-A source for chained ops), a carry flag (feeds cin for ADD_CARRY), and saturating op/error counters.

Parameters:
BUS_WIDTH, 8, operand/result width; must match the ALU instance.
CNT_WIDTH, 16, width of op_count and err_count.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset; asynchronous, active-high
in_valid  in  1  operation offered
in_ready  out  1  controller can accept
in_opcode  in  4  1 ADD, 2 ADD_CARRY, 3 SUB, 4 INC, 5 DEC, 6 AND, 7 NOT, 8 RL, 9 RR; 0 and 10-15 invalid
in_a  in  BUS_WIDTH  operand A
in_b  in  BUS_WIDTH  operand B
in_use_acc  in  1  1: use accumulator as A; in_a is ignored
alu_opcode  out  4  to ALU
alu_a  out  BUS_WIDTH  to ALU
alu_b  out  BUS_WIDTH  to ALU
alu_cin  out  1  to ALU
alu_y  in  BUS_WIDTH  from ALU
alu_cout, alu_borrow, alu_zero, alu_parity, alu_invalid_op  in  1 each  from ALU
out_valid  out  1  result held
out_ready  in  1  downstream accepts
out_y  out  BUS_WIDTH  captured result
out_flags  out  5  {invalid_op, parity, zero, borrow, cout}
acc  out  BUS_WIDTH  accumulator
carry_flag  out  1  stored carry
op_count  out  CNT_WIDTH  retired valid ops, saturating
err_count  out  CNT_WIDTH  retired invalid ops, saturating

Behaviour:
- One clock; reset is asynchronous and active-high. On rst: state IDLE; every registered output, including alu_* drives, acc, carry_flag, counters, out_y and out_flags, is 0; out_valid=0.
- FSM states IDLE, EXEC, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept occurs when in_valid && in_ready.
  - alu_opcode <= in_opcode.
  - alu_a <= in_use_acc ? acc : in_a.
  - alu_b <= in_b.
  - alu_cin <= (in_opcode==2) ? carry_flag : 0.
  - state -> EXEC.
- EXEC lasts exactly one cycle; the ALU settles combinationally from the registered drives. At the end of EXEC:
  - Capture out_y <= alu_y and out_flags <= the ALU flags.
  - Set out_valid and move to DONE.
- Latency: accept edge to out_valid high = 2 edges. Peak throughput is one op per 2 cycles, achieved when DONE hands off directly to EXEC.
- DONE holds out_y and out_flags stable until out_ready.
  - out_ready with no accept: go to IDLE, out_valid=0.
  - out_ready with a simultaneous accept: go to EXEC, out_valid=0.
- Invalid op: alu_invalid_op=1, or opcode 0 / 10-15 decoded locally (OR of both). Response:
  - out_y forced 0; out_flags = 5'b10000.
  - acc and carry_flag unchanged.
  - err_count increments.
- Valid op at capture:
  - acc <= alu_y.
  - op_count increments.
  - carry_flag <= alu_cout for opcodes 1 and 2; unchanged for all others.
- Counters saturate at all-ones; they never wrap.
- in_* is sampled only at accept; changes at any other time are ignored. out_ready is ignored outside DONE.
- Reset in any state aborts the in-flight op: nothing is retired and counters are not incremented.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_INVALID=0 … OP_RR=9);
  - flag bit indices (FLAG_COUT=0 … FLAG_INVALID=4);
  - an FSM state encoding.
- The ALU itself is shared via alu_pkg so the ALU and this controller agree.
- One natural sub-module: sat_counter (parameter WIDTH; ports clk, rst, inc, count), instantiated twice.

Test Plan:
- Reset mid-EXEC: accept ADD 9,33, assert rst during EXEC -> all outputs 0, out_valid never rises, op_count=0.
- ADD 200,100 (use_acc=0) -> out_valid 2 edges after accept, out_y=44, cout=1, carry_flag=1, acc=44. Then ADD_CARRY 24,53 -> alu_cin=1, out_y=78, carry_flag=0.
- ADD 9,33 then INC with use_acc=1 -> alu_a=42, out_y=43, acc=43, op_count=2.
- Opcode 12, a=5: out_y=0, out_flags=5'b10000, err_count=1, acc unchanged. Repeat with opcode 0 -> err_count=2.
- Backpressure: out_ready low for 5 cycles after out_valid -> out_y/out_flags stable, in_ready=0. Raise out_ready with in_valid=1 and a new op -> same-edge handoff, next result valid 2 edges later.
- Saturation with CNT_WIDTH=2: retire 5 valid ops -> op_count=3, no wrap.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag positions, issue FSM encoding and a
// behavioural ALU evaluation function used by the ALU and its controllers.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [3:0] OP_INVALID   = 4'd0;
    localparam logic [3:0] OP_ADD       = 4'd1;
    localparam logic [3:0] OP_ADD_CARRY = 4'd2;
    localparam logic [3:0] OP_SUB       = 4'd3;
    localparam logic [3:0] OP_INC       = 4'd4;
    localparam logic [3:0] OP_DEC       = 4'd5;
    localparam logic [3:0] OP_AND       = 4'd6;
    localparam logic [3:0] OP_NOT       = 4'd7;
    localparam logic [3:0] OP_RL        = 4'd8;
    localparam logic [3:0] OP_RR        = 4'd9;

    localparam int FLAG_COUT    = 0;
    localparam int FLAG_BORROW  = 1;
    localparam int FLAG_ZERO    = 2;
    localparam int FLAG_PARITY  = 3;
    localparam int FLAG_INVALID = 4;

    // Flag word reported for any rejected opcode: only the invalid bit set.
    localparam logic [4:0] FLAGS_INVALID_ONLY = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] y;
        logic                 cout;
        logic                 borrow;
        logic                 zero;
        logic                 parity;
        logic                 invalid;
    } alu_res_t;

    function automatic logic opcode_is_valid(input logic [3:0] op);
        return (op != OP_INVALID) && (op <= OP_RR);
    endfunction

    function automatic alu_res_t alu_eval(input logic [3:0]           op,
                                          input logic [ALU_WIDTH-1:0] a,
                                          input logic [ALU_WIDTH-1:0] b,
                                          input logic                 cin);
        alu_res_t             r;
        logic [ALU_WIDTH:0]   wide;
        logic [ALU_WIDTH:0]   one;
        r    = '0;
        wide = '0;
        one  = {{ALU_WIDTH{1'b0}}, 1'b1};
        case (op)
            OP_ADD: begin
                wide     = {1'b0, a} + {1'b0, b};
                r.y      = wide[ALU_WIDTH-1:0];
                r.cout   = wide[ALU_WIDTH];
            end
            OP_ADD_CARRY: begin
                wide     = {1'b0, a} + {1'b0, b} + {{ALU_WIDTH{1'b0}}, cin};
                r.y      = wide[ALU_WIDTH-1:0];
                r.cout   = wide[ALU_WIDTH];
            end
            OP_SUB: begin
                wide     = {1'b0, a} - {1'b0, b};
                r.y      = wide[ALU_WIDTH-1:0];
                r.borrow = wide[ALU_WIDTH];
            end
            OP_INC: begin
                wide     = {1'b0, a} + one;
                r.y      = wide[ALU_WIDTH-1:0];
                r.cout   = wide[ALU_WIDTH];
            end
            OP_DEC: begin
                wide     = {1'b0, a} - one;
                r.y      = wide[ALU_WIDTH-1:0];
                r.borrow = wide[ALU_WIDTH];
            end
            OP_AND:  r.y = a & b;
            OP_NOT:  r.y = ~a;
            OP_RL:   r.y = {a[ALU_WIDTH-2:0], a[ALU_WIDTH-1]};
            OP_RR:   r.y = {a[0], a[ALU_WIDTH-1:1]};
            default: r.invalid = 1'b1;
        endcase
        r.zero   = (r.y == '0);
        r.parity = ^r.y;
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Increment on request unless already saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/retire controller wrapped around a combinational ALU: registers the
// ALU drives at accept, captures the ALU outputs one cycle later, and holds
// the result for a valid/ready consumer. Keeps accumulator, carry and
// saturating retire counters.
//
// state   | meaning
// IDLE    | no op in flight, ready to accept
// EXEC    | ALU drives registered, ALU settling; capture on next edge
// DONE    | result held on out_*, waiting for out_ready
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_opcode,
    input  logic [BUS_WIDTH-1:0] in_a,
    input  logic [BUS_WIDTH-1:0] in_b,
    input  logic                 in_use_acc,
    output logic [3:0]           alu_opcode,
    output logic [BUS_WIDTH-1:0] alu_a,
    output logic [BUS_WIDTH-1:0] alu_b,
    output logic                 alu_cin,
    input  logic [BUS_WIDTH-1:0] alu_y,
    input  logic                 alu_cout,
    input  logic                 alu_borrow,
    input  logic                 alu_zero,
    input  logic                 alu_parity,
    input  logic                 alu_invalid_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_y,
    output logic [4:0]           out_flags,
    output logic [BUS_WIDTH-1:0] acc,
    output logic                 carry_flag,
    output logic [CNT_WIDTH-1:0] op_count,
    output logic [CNT_WIDTH-1:0] err_count
);

    issue_state_t state;
    logic         accept;
    logic         op_bad;
    logic         retire_ok;
    logic         retire_err;
    logic [4:0]   alu_flags;

    assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // The ALU's own invalid flag is OR'd with a local decode so an ALU that
    // silently treats a reserved opcode as a no-op still gets rejected here.
    assign op_bad     = alu_invalid_op || !opcode_is_valid(alu_opcode);
    assign retire_ok  = (state == ST_EXEC) && !op_bad;
    assign retire_err = (state == ST_EXEC) && op_bad;

    // Pack ALU flag inputs into the out_flags bit order.
    always_comb begin
        alu_flags               = '0;
        alu_flags[FLAG_COUT]    = alu_cout;
        alu_flags[FLAG_BORROW]  = alu_borrow;
        alu_flags[FLAG_ZERO]    = alu_zero;
        alu_flags[FLAG_PARITY]  = alu_parity;
        alu_flags[FLAG_INVALID] = alu_invalid_op;
    end

    // Issue FSM: registers ALU drives at accept, captures result in EXEC,
    // holds it in DONE until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cin    <= 1'b0;
            out_valid  <= 1'b0;
            out_y      <= '0;
            out_flags  <= '0;
            acc        <= '0;
            carry_flag <= 1'b0;
        end else begin
            if (accept) begin
                alu_opcode <= in_opcode;
                alu_a      <= in_use_acc ? acc : in_a;
                alu_b      <= in_b;
                alu_cin    <= (in_opcode == OP_ADD_CARRY) ? carry_flag : 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                    if (op_bad) begin
                        out_y     <= '0;
                        out_flags <= FLAGS_INVALID_ONLY;
                    end else begin
                        out_y     <= alu_y;
                        out_flags <= alu_flags;
                        acc       <= alu_y;
                        if ((alu_opcode == OP_ADD) || (alu_opcode == OP_ADD_CARRY)) begin
                            carry_flag <= alu_cout;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= accept ? ST_EXEC : ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_op_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire_ok),
        .count (op_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_err_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire_err),
        .count (err_count)
    );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU in the loop.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int BW = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_opcode;
    logic [BW-1:0] in_a;
    logic [BW-1:0] in_b;
    logic          in_use_acc;
    logic [3:0]    alu_opcode;
    logic [BW-1:0] alu_a;
    logic [BW-1:0] alu_b;
    logic          alu_cin;
    logic [BW-1:0] alu_y;
    logic          alu_cout;
    logic          alu_borrow;
    logic          alu_zero;
    logic          alu_parity;
    logic          alu_invalid_op;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_y;
    logic [4:0]    out_flags;
    logic [BW-1:0] acc;
    logic          carry_flag;
    logic [CW-1:0] op_count;
    logic [CW-1:0] err_count;

    alu_res_t      alu_r;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb alu_r = alu_eval(alu_opcode, alu_a, alu_b, alu_cin);
    assign alu_y          = alu_r.y;
    assign alu_cout       = alu_r.cout;
    assign alu_borrow     = alu_r.borrow;
    assign alu_zero       = alu_r.zero;
    assign alu_parity     = alu_r.parity;
    assign alu_invalid_op = alu_r.invalid;

    alu_issue_ctrl #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_opcode      (in_opcode),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_use_acc     (in_use_acc),
        .alu_opcode     (alu_opcode),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_cin        (alu_cin),
        .alu_y          (alu_y),
        .alu_cout       (alu_cout),
        .alu_borrow     (alu_borrow),
        .alu_zero       (alu_zero),
        .alu_parity     (alu_parity),
        .alu_invalid_op (alu_invalid_op),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_y          (out_y),
        .out_flags      (out_flags),
        .acc            (acc),
        .carry_flag     (carry_flag),
        .op_count       (op_count),
        .err_count      (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer an op at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [BW-1:0] a,
                         input logic [BW-1:0] b, input logic use_acc);
        int n;
        in_valid   = 1'b1;
        in_opcode  = op;
        in_a       = a;
        in_b       = b;
        in_use_acc = use_acc;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", {31'd0, n < 20}, 32'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        in_opcode = 4'd0;
        in_a      = '0;
        in_b      = '0;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        in_valid   = 1'b0;
        in_opcode  = 4'd0;
        in_a       = '0;
        in_b       = '0;
        in_use_acc = 1'b0;
        out_ready  = 1'b0;
        do_reset();

        // Reset state
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_op_count", {30'd0, op_count}, 32'd0);
        chk("rst_acc", {24'd0, acc}, 32'd0);

        // Reset mid-EXEC aborts the op
        issue(OP_ADD, 8'd9, 8'd33, 1'b0);
        chk("exec_alu_a", {24'd0, alu_a}, 32'd9);
        chk("exec_alu_b", {24'd0, alu_b}, 32'd33);
        #1 rst = 1'b1;
        #1;
        chk("abort_alu_a", {24'd0, alu_a}, 32'd0);
        chk("abort_alu_opcode", {28'd0, alu_opcode}, 32'd0);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid_1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("abort_out_valid_2", {31'd0, out_valid}, 32'd0);
        chk("abort_op_count", {30'd0, op_count}, 32'd0);
        chk("abort_acc", {24'd0, acc}, 32'd0);

        // ADD 200+100 = 300 -> 44 with carry out; latency of 2 edges
        issue(OP_ADD, 8'd200, 8'd100, 1'b0);
        chk("add_lat_1", {31'd0, out_valid}, 32'd0);
        chk("add_cin", {31'd0, alu_cin}, 32'd0);
        @(negedge clk);
        chk("add_lat_2", {31'd0, out_valid}, 32'd1);
        chk("add_y", {24'd0, out_y}, 32'd44);
        chk("add_flags", {27'd0, out_flags}, 32'b01001);
        chk("add_carry", {31'd0, carry_flag}, 32'd1);
        chk("add_acc", {24'd0, acc}, 32'd44);
        chk("add_in_ready_blocked", {31'd0, in_ready}, 32'd0);
        retire();
        chk("add_retired", {31'd0, out_valid}, 32'd0);

        // ADD_CARRY 24+53+1 = 78, carry out 0
        issue(OP_ADD_CARRY, 8'd24, 8'd53, 1'b0);
        chk("adc_cin", {31'd0, alu_cin}, 32'd1);
        @(negedge clk);
        chk("adc_y", {24'd0, out_y}, 32'd78);
        chk("adc_flags", {27'd0, out_flags}, 32'b00000);
        chk("adc_carry", {31'd0, carry_flag}, 32'd0);
        chk("adc_op_count", {30'd0, op_count}, 32'd2);
        retire();

        // Chained: ADD 9+33 = 42, then INC on accumulator -> 43
        do_reset();
        issue(OP_ADD, 8'd9, 8'd33, 1'b0);
        @(negedge clk);
        chk("chain_add_y", {24'd0, out_y}, 32'd42);
        retire();
        issue(OP_INC, 8'd200, 8'd0, 1'b1);
        chk("inc_alu_a", {24'd0, alu_a}, 32'd42);
        @(negedge clk);
        chk("inc_y", {24'd0, out_y}, 32'd43);
        chk("inc_acc", {24'd0, acc}, 32'd43);
        chk("inc_op_count", {30'd0, op_count}, 32'd2);
        retire();

        // Invalid opcodes 12 and 0
        issue(4'd12, 8'd5, 8'd0, 1'b0);
        @(negedge clk);
        chk("inv12_y", {24'd0, out_y}, 32'd0);
        chk("inv12_flags", {27'd0, out_flags}, 32'b10000);
        chk("inv12_err", {30'd0, err_count}, 32'd1);
        chk("inv12_acc", {24'd0, acc}, 32'd43);
        retire();
        issue(4'd0, 8'd5, 8'd7, 1'b0);
        @(negedge clk);
        chk("inv0_flags", {27'd0, out_flags}, 32'b10000);
        chk("inv0_err", {30'd0, err_count}, 32'd2);
        chk("inv0_op_count", {30'd0, op_count}, 32'd2);
        chk("inv0_acc", {24'd0, acc}, 32'd43);
        retire();

        // Backpressure: SUB 10-3 = 7 held while a new op is offered
        issue(OP_SUB, 8'd10, 8'd3, 1'b0);
        @(negedge clk);
        chk("sub_valid", {31'd0, out_valid}, 32'd1);
        in_valid   = 1'b1;
        in_opcode  = OP_AND;
        in_a       = 8'hF0;
        in_b       = 8'h3C;
        in_use_acc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_y", {24'd0, out_y}, 32'd7);
            chk("bp_flags", {27'd0, out_flags}, 32'b01000);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("handoff_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("handoff_valid_low", {31'd0, out_valid}, 32'd0);
        chk("handoff_alu_opcode", {28'd0, alu_opcode}, 32'd6);
        chk("handoff_alu_a", {24'd0, alu_a}, 32'hF0);
        @(negedge clk);
        chk("handoff_valid", {31'd0, out_valid}, 32'd1);
        chk("and_y", {24'd0, out_y}, 32'h30);
        chk("and_flags", {27'd0, out_flags}, 32'b00000);
        chk("and_op_count_sat", {30'd0, op_count}, 32'd3);
        retire();

        // Saturation with 2-bit counters; NOT leaves carry_flag alone
        do_reset();
        issue(OP_ADD, 8'd200, 8'd100, 1'b0);
        @(negedge clk);
        chk("sat_cnt_1", {30'd0, op_count}, 32'd1);
        retire();
        for (int i = 0; i < 4; i++) begin
            issue(OP_NOT, 8'h0F, 8'd0, 1'b0);
            @(negedge clk);
            chk("sat_not_y", {24'd0, out_y}, 32'hF0);
            chk("sat_cnt", {30'd0, op_count}, (i == 0) ? 32'd2 : 32'd3);
            chk("sat_carry_kept", {31'd0, carry_flag}, 32'd1);
            retire();
        end
        chk("sat_err_count", {30'd0, err_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
